// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_ctrl_pkg                                                    |
// | Purpose : Shared types and constants for the pipeline controller: FSM      |
// |           state encoding, stall vector width, stage indices and the        |
// |           Stop/NoStop values seen by each pipeline register.               |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int STALL_W = 7;
  localparam int REQ_W   = 6;

  localparam logic [STALL_W-1:0] STALL_ALL  = 7'h7F;
  localparam logic [STALL_W-1:0] STALL_NONE = 7'h00;

  // Per-register freeze values
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Pipeline register indices within the stall vector
  localparam int STAGE_PC     = 0;
  localparam int STAGE_IF     = 1;
  localparam int STAGE_ID     = 2;
  localparam int STAGE_EX     = 3;
  localparam int STAGE_EX_MEM = 4;
  localparam int STAGE_MEM_WB = 5;
  localparam int STAGE_COMMIT = 6;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_IDLE_WAIT = 2'd2
  } state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_stall_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stall_encode                                                     |
// | Purpose : Turns the 6-bit per-stage stall request into the 7-bit           |
// |           thermometer stall vector: the highest requesting stage k freezes |
// |           registers 0..k, everything downstream keeps flowing.             |
// | Ports   : stallreq [5:0] in  - level stall requests                        |
// |           stall    [6:0] out - thermometer freeze vector                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module stall_encode
  import pipe_ctrl_pkg::*;
(
  input  logic [REQ_W-1:0]   stallreq,
  output logic [STALL_W-1:0] stall
);

  // Register k is frozen when any stage at or beyond k asks for a stall
  for (genvar k = 0; k < REQ_W; k++) begin : g_therm
    assign stall[k] = |stallreq[REQ_W-1:k];
  end

  // Commit register never freezes on a plain stall request
  assign stall[STAGE_COMMIT] = NO_STOP;

endmodule : stall_encode
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipe_ctrl                                                        |
// | Purpose : Central pipeline controller. Merges stall requests, sequences    |
// |           exception/ertn redirects into a one-cycle flush with new PC,     |
// |           parks the core in IDLE until an interrupt, and keeps stall       |
// |           statistics plus a stall watchdog.                                |
// | Ports   : clk, rst (async, active-high)                                    |
// |           stallreq[5:0], excp_valid, excp_entry[31:0], ertn_valid,         |
// |           ertn_era[31:0], idle_valid, int_pending                  (in)    |
// |           stall[6:0] (comb), flush, new_pc[31:0], idle_state,              |
// |           stall_cycles[CNT_W-1:0], stall_timeout                   (out)   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_W-1:0]   stallreq,
  input  logic               excp_valid,
  input  logic [31:0]        excp_entry,
  input  logic               ertn_valid,
  input  logic [31:0]        ertn_era,
  input  logic               idle_valid,
  input  logic               int_pending,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               idle_state,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               stall_timeout
);

  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(STALL_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(STALL_TIMEOUT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [STALL_W-1:0] req_stall;
  logic               pc_load;
  logic [31:0]        pc_target;
  logic [WD_W-1:0]    wd_cnt;
  logic               wd_hit;

  stall_encode u_stall_encode (
    .stallreq (stallreq),
    .stall    (req_stall)
  );

  // Next-state and combinational stall
  always_comb begin
    state_nxt = state;
    stall     = STALL_NONE;
    pc_load   = 1'b0;
    pc_target = excp_entry;
    case (state)
      ST_RUN: begin
        if (excp_valid) begin
          stall     = STALL_ALL;
          state_nxt = ST_FLUSH;
          pc_load   = 1'b1;
        end else if (ertn_valid) begin
          stall     = STALL_ALL;
          state_nxt = ST_FLUSH;
          pc_load   = 1'b1;
          pc_target = ertn_era;
        end else if (idle_valid) begin
          stall     = STALL_ALL;
          state_nxt = ST_IDLE_WAIT;
        end else begin
          stall     = req_stall;
        end
      end
      ST_FLUSH: begin
        // Flush cycle ignores every request
        state_nxt = ST_RUN;
      end
      ST_IDLE_WAIT: begin
        stall = STALL_ALL;
        if (excp_valid) begin
          state_nxt = ST_FLUSH;
          pc_load   = 1'b1;
        end else if (int_pending) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // flush/idle_state are registered copies of the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      flush      <= 1'b0;
      idle_state <= 1'b0;
      new_pc     <= 32'h0;
    end else begin
      state      <= state_nxt;
      flush      <= (state_nxt == ST_FLUSH);
      idle_state <= (state_nxt == ST_IDLE_WAIT);
      if (pc_load) begin
        new_pc <= pc_target;
      end
    end
  end

  // Watchdog: consecutive RUN cycles with a pending stall request
  assign wd_hit = (state == ST_RUN) && (stallreq != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (!wd_hit) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      // Count reaches the limit on this edge (or already sits there)
      if (wd_hit && (wd_cnt >= WD_LAST)) begin
        stall_timeout <= 1'b1;
      end
    end
  end

  // Saturating statistics of cycles with the PC register frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((stall[STAGE_PC] == STOP) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pipe_ctrl                                                     |
// | Purpose : Self-checking bench for pipe_ctrl: directed scenarios followed   |
// |           by randomized traffic, compared against a behavioural model.     |
// |           A second instance with a narrow counter exercises saturation.    |
// | Ports   : none                                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam int TO     = 4;
  localparam int CNT_W  = 32;
  localparam int CNT_W2 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stallreq = '0;
  logic        excp_valid = 1'b0;
  logic [31:0] excp_entry = '0;
  logic        ertn_valid = 1'b0;
  logic [31:0] ertn_era = '0;
  logic        idle_valid = 1'b0;
  logic        int_pending = 1'b0;

  logic [6:0]        stall, s_stall;
  logic              flush, s_flush;
  logic [31:0]       new_pc, s_new_pc;
  logic              idle_state, s_idle_state;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W2-1:0] s_stall_cycles;
  logic              stall_timeout, s_stall_timeout;

  pipe_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .excp_valid(excp_valid), .excp_entry(excp_entry),
    .ertn_valid(ertn_valid), .ertn_era(ertn_era),
    .idle_valid(idle_valid), .int_pending(int_pending),
    .stall(stall), .flush(flush), .new_pc(new_pc), .idle_state(idle_state),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  pipe_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(CNT_W2)) dut_sat (
    .clk(clk), .rst(rst), .stallreq(stallreq),
    .excp_valid(excp_valid), .excp_entry(excp_entry),
    .ertn_valid(ertn_valid), .ertn_era(ertn_era),
    .idle_valid(idle_valid), .int_pending(int_pending),
    .stall(s_stall), .flush(s_flush), .new_pc(s_new_pc), .idle_state(s_idle_state),
    .stall_cycles(s_stall_cycles), .stall_timeout(s_stall_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit          m_flush, m_idle, m_to;
  logic [31:0] m_pc;
  longint      m_cnt, m_cnt2;
  int          m_run_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] therm(input logic [5:0] req);
    logic [6:0] v = '0;
    for (int k = 0; k < 6; k++)
      if (req[k]) v = 7'((1 << (k + 1)) - 1);
    return v;
  endfunction

  task automatic model_reset();
    m_flush = 0; m_idle = 0; m_to = 0; m_pc = '0;
    m_cnt = 0; m_cnt2 = 0; m_run_stall = 0;
  endtask

  task automatic check_regs();
    check("flush", 64'(flush), 64'(m_flush));
    check("idle_state", 64'(idle_state), 64'(m_idle));
    if (m_flush) check("new_pc", 64'(new_pc), 64'(m_pc));
    check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
    check("stall_cycles_sat", 64'(s_stall_cycles), 64'(m_cnt2));
    check("stall_timeout", 64'(stall_timeout), 64'(m_to));
  endtask

  // One clock: drive at negedge, check stall mid-low-phase, check regs after posedge
  task automatic step(input logic [5:0] req, input bit ex, input logic [31:0] ent,
                      input bit er, input logic [31:0] era, input bit idl, input bit ip);
    logic [6:0] exp_stall;
    bit in_run;
    @(negedge clk);
    stallreq = req; excp_valid = ex; excp_entry = ent; ertn_valid = er;
    ertn_era = era; idle_valid = idl; int_pending = ip;
    in_run = !m_flush && !m_idle;
    if (m_flush)                    exp_stall = 7'h00;
    else if (m_idle)                exp_stall = 7'h7F;
    else if (ex || er || idl)       exp_stall = 7'h7F;
    else                            exp_stall = therm(req);
    #1;
    check("stall", 64'(stall), 64'(exp_stall));
    @(posedge clk);
    #1;
    if (exp_stall[0]) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt2 < 7) m_cnt2++;
    end
    if (in_run && req != 0) begin
      if (m_run_stall < TO) m_run_stall++;
      if (m_run_stall == TO) m_to = 1;
    end else begin
      m_run_stall = 0;
    end
    if (m_flush) begin
      m_flush = 0;
    end else if (m_idle) begin
      if (ex) begin m_flush = 1; m_pc = ent; m_idle = 0; end
      else if (ip) m_idle = 0;
    end else if (ex) begin
      m_flush = 1; m_pc = ent;
    end else if (er) begin
      m_flush = 1; m_pc = era;
    end else if (idl) begin
      m_idle = 1;
    end
    check_regs();
  endtask

  // Asynchronous reset pulse placed away from any clock edge
  task automatic do_reset();
    @(negedge clk);
    stallreq = '0; excp_valid = 0; ertn_valid = 0; idle_valid = 0; int_pending = 0;
    #1 rst = 1;
    #1;
    model_reset();
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_new_pc", 64'(new_pc), 64'h0);
    check("rst_idle", 64'(idle_state), 64'h0);
    check("rst_cycles", 64'(stall_cycles), 64'h0);
    check("rst_timeout", 64'(stall_timeout), 64'h0);
    #1 rst = 0;
  endtask

  initial begin
    do_reset();
    // Deep stall request held three cycles
    repeat (3) step(6'b100000, 0, 0, 0, 0, 0, 0);
    check("cycles_after3", 64'(stall_cycles), 64'd3);
    // Mid-pipe request, then release
    step(6'b000101, 0, 0, 0, 0, 0, 0);
    step(6'b000000, 0, 0, 0, 0, 0, 0);
    // Exception beats ertn and stall requests
    step(6'h3F, 1, 32'h1C00_8000, 1, 32'hDEAD_BEEF, 0, 0);
    check("excp_new_pc", 64'(new_pc), 64'h1C00_8000);
    step(6'h3F, 1, 32'h1111_1111, 0, 0, 0, 0);  // ignored during flush
    step(6'h00, 1, 32'h2000_0000, 0, 0, 0, 0);  // back-to-back accept
    step(6'h00, 0, 0, 0, 0, 0, 0);
    step(6'h00, 0, 0, 1, 32'h3000_0040, 0, 0);  // ertn redirect
    step(6'h00, 0, 0, 0, 0, 0, 0);
    // Idle, wake on interrupt
    step(6'h00, 0, 0, 0, 0, 1, 0);
    repeat (10) step(6'h00, 0, 0, 0, 0, 0, 0);
    step(6'h00, 0, 0, 0, 0, 0, 1);
    step(6'h00, 0, 0, 0, 0, 0, 0);
    // Idle, leave through an exception
    step(6'h00, 0, 0, 0, 0, 1, 0);
    repeat (3) step(6'h00, 0, 0, 0, 0, 0, 0);
    step(6'h00, 1, 32'h1C00_4000, 0, 0, 0, 1);
    check("idle_excp_pc", 64'(new_pc), 64'h1C00_4000);
    step(6'h00, 0, 0, 0, 0, 0, 0);
    // Reset in the middle of IDLE_WAIT
    step(6'h00, 0, 0, 0, 0, 1, 0);
    step(6'h00, 0, 0, 0, 0, 0, 0);
    do_reset();
    // Watchdog: short burst then gap stays clear, full burst trips
    repeat (3) step(6'b000001, 0, 0, 0, 0, 0, 0);
    step(6'b000000, 0, 0, 0, 0, 0, 0);
    check("wd_short", 64'(stall_timeout), 64'h0);
    repeat (4) step(6'b000001, 0, 0, 0, 0, 0, 0);
    check("wd_trip", 64'(stall_timeout), 64'h1);
    repeat (2) step(6'b000000, 0, 0, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] req;
      if (i % 250 == 0) do_reset();
      req = ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'h0;
      step(req, $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 15) == 0,
           $urandom, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_ctrl
`default_nettype wire
